// File: rtl/window_slide_wrapper.sv
// rtl/window_slide_wrapper.sv - image RAM with a KxK binary sliding-window reader
module window_slide_wrapper #(
    parameter int DATA_WIDTH      = 8,
    parameter int IMAGE_ROW_LEN   = 200,
    parameter int IMAGE_COL_LEN   = 60,
    parameter int DATA_ADDR_WIDTH = $clog2(IMAGE_ROW_LEN * IMAGE_COL_LEN + 1),
    parameter int KERNEL_SIZE     = 16,
    parameter int STRIDE          = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_ADDR_WIDTH-1:0] ram_in_addr,
    input  logic [DATA_WIDTH-1:0]      ram_in_data,
    input  logic                       ram_in_wen,
    input  logic                       start,
    input  logic                       slide,
    output logic                       y_out [KERNEL_SIZE*KERNEL_SIZE-1:0],
    output logic                       valid
);

    localparam int IMAGE_SIZE = IMAGE_ROW_LEN * IMAGE_COL_LEN;
    localparam int KK         = KERNEL_SIZE * KERNEL_SIZE;
    // Coordinate width leaves headroom for origin + stride and origin + kernel offset.
    localparam int CW         = $clog2(IMAGE_ROW_LEN + IMAGE_COL_LEN + STRIDE + KERNEL_SIZE + 1);
    localparam int KW         = $clog2(KERNEL_SIZE + 1);
    localparam int IW         = $clog2(KK);

    localparam logic [CW-1:0] ROW_MAX = CW'(IMAGE_ROW_LEN - KERNEL_SIZE);
    localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_COL_LEN - KERNEL_SIZE);
    localparam logic [CW-1:0] STEP    = CW'(STRIDE);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LAST  = 3'd2;
    localparam logic [2:0] OUT   = 3'd3;
    localparam logic [2:0] READY = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [DATA_WIDTH-1:0]      mem [IMAGE_SIZE];
    logic [DATA_WIDTH-1:0]      rd_data;
    logic [DATA_ADDR_WIDTH-1:0] rd_addr;

    logic [2:0]    state;
    logic [CW-1:0] r0;
    logic [CW-1:0] c0;
    logic [KW-1:0] fi;
    logic [KW-1:0] fj;
    logic [IW-1:0] cnt;
    logic          cap_en;
    logic [IW-1:0] cap_idx;
    logic [KK-1:0] win_buf;

    logic has_next_col;
    logic has_next_row;

    assign has_next_col = (c0 + STEP) <= COL_MAX;
    assign has_next_row = (r0 + STEP) <= ROW_MAX;

    // Row-major address of pixel (r0+fi, c0+fj) for the read issued this cycle.
    assign rd_addr = DATA_ADDR_WIDTH'(r0 + CW'(fi)) * DATA_ADDR_WIDTH'(IMAGE_COL_LEN)
                   + DATA_ADDR_WIDTH'(c0 + CW'(fj));

    // Image RAM: guarded writes, registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_in_wen && (ram_in_addr < DATA_ADDR_WIDTH'(IMAGE_SIZE))) begin
            mem[ram_in_addr] <= ram_in_data;
        end
        if (state == FETCH) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Scan sequencer: origin stepping, read issue, bit capture and window publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            r0      <= '0;
            c0      <= '0;
            fi      <= '0;
            fj      <= '0;
            cnt     <= '0;
            cap_en  <= 1'b0;
            cap_idx <= '0;
            win_buf <= '0;
            valid   <= 1'b0;
            for (int k = 0; k < KK; k++) begin
                y_out[k] <= 1'b0;
            end
        end else begin
            valid  <= 1'b0;
            cap_en <= 1'b0;
            // Read data arrives one cycle after its address; fold it into the buffer.
            if (cap_en) begin
                win_buf[cap_idx] <= |rd_data;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r0    <= '0;
                        c0    <= '0;
                        fi    <= '0;
                        fj    <= '0;
                        cnt   <= '0;
                        state <= FETCH;
                    end
                end
                READY: begin
                    if (start) begin
                        r0    <= '0;
                        c0    <= '0;
                        fi    <= '0;
                        fj    <= '0;
                        cnt   <= '0;
                        state <= FETCH;
                    end else if (slide) begin
                        if (has_next_col) begin
                            c0 <= c0 + STEP;
                        end else begin
                            c0 <= '0;
                            r0 <= r0 + STEP;
                        end
                        fi    <= '0;
                        fj    <= '0;
                        cnt   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    cap_en  <= 1'b1;
                    cap_idx <= cnt;
                    if (fj == KW'(KERNEL_SIZE - 1)) begin
                        fj <= '0;
                        fi <= fi + 1'b1;
                    end else begin
                        fj <= fj + 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == IW'(KK - 1)) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    state <= OUT;
                end
                OUT: begin
                    for (int k = 0; k < KK; k++) begin
                        y_out[k] <= win_buf[k];
                    end
                    valid <= 1'b1;
                    state <= (!has_next_col && !has_next_row) ? DONE : READY;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_slide_wrapper.sv
// tb/tb_window_slide_wrapper.sv - randomized self-checking bench for window_slide_wrapper
module tb_window_slide_wrapper;

    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int K    = 4;
    localparam int S    = 2;
    localparam int KK   = K * K;
    localparam int SIZE = ROWS * COLS;
    localparam int AW   = 7;
    localparam int LAT  = KK + 2;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ram_in_addr;
    logic [7:0]    ram_in_data;
    logic          ram_in_wen;
    logic          start;
    logic          slide;
    logic          y_out [KK-1:0];
    logic          valid;

    logic [7:0] model [SIZE];
    int n_checks;
    int n_fail;

    window_slide_wrapper #(
        .DATA_WIDTH(8),
        .IMAGE_ROW_LEN(ROWS),
        .IMAGE_COL_LEN(COLS),
        .DATA_ADDR_WIDTH(AW),
        .KERNEL_SIZE(K),
        .STRIDE(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ram_in_addr(ram_in_addr),
        .ram_in_data(ram_in_data),
        .ram_in_wen(ram_in_wen),
        .start(start),
        .slide(slide),
        .y_out(y_out),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [KK-1:0] expected_window(input int r, input int c);
        logic [KK-1:0] w;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w[i*K+j] = (model[(r+i)*COLS + (c+j)] != 8'd0);
            end
        end
        return w;
    endfunction

    function automatic logic [KK-1:0] packed_y();
        logic [KK-1:0] w;
        for (int k = 0; k < KK; k++) begin
            w[k] = y_out[k];
        end
        return w;
    endfunction

    task automatic write_word(input int addr, input logic [7:0] d);
        @(negedge clk);
        ram_in_wen  = 1'b1;
        ram_in_addr = AW'(addr);
        ram_in_data = d;
        if (addr < SIZE) model[addr] = d;
        @(negedge clk);
        ram_in_wen = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic sl);
        @(negedge clk);
        start = s;
        slide = sl;
        @(negedge clk);
        start = 1'b0;
        slide = 1'b0;
    endtask

    task automatic expect_window(input string name, input int r, input int c);
        int lat;
        logic [KK-1:0] exp_w;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid && lat < LAT + 20);
        exp_w = expected_window(r, c);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d (window r0=%0d c0=%0d)", name, lat, LAT, r, c);
        end
        n_checks++;
        if (packed_y() !== exp_w) begin
            n_fail++;
            $display("FAIL %s window r0=%0d c0=%0d: got %h expected %h", name, r, c, packed_y(), exp_w);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid width: got %b expected 0 one cycle after strobe", name, valid);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d valid strobes, expected 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || packed_y() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b y=%h expected valid=0 y=0", valid, packed_y());
        end
        rst = 1'b0;
        pulse(1'b0, 1'b1);
        check_quiet("slide_in_idle", 40);
    endtask

    task automatic test_load_and_first_window();
        for (int a = 0; a < SIZE; a++) begin
            write_word(a, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'd0);
        end
        pulse(1'b1, 1'b0);
        expect_window("first_window", 0, 0);
    endtask

    task automatic test_full_scan();
        int windows;
        logic [KK-1:0] held;
        windows = 0;
        pulse(1'b1, 1'b0);
        for (int r = 0; r <= ROWS - K; r += S) begin
            for (int c = 0; c <= COLS - K; c += S) begin
                if (r != 0 || c != 0) pulse(1'b0, 1'b1);
                expect_window("scan", r, c);
                windows++;
            end
        end
        n_checks++;
        if (windows != ((ROWS - K) / S + 1) * ((COLS - K) / S + 1) || windows != 16) begin
            n_fail++;
            $display("FAIL scan_count: got %0d windows expected 16", windows);
        end
        held = packed_y();
        pulse(1'b0, 1'b1);
        check_quiet("slide_in_done", 40);
        n_checks++;
        if (packed_y() !== expected_window(ROWS - K, COLS - K)) begin
            n_fail++;
            $display("FAIL done_hold: got %h expected %h", packed_y(), held);
        end
        pulse(1'b1, 1'b0);
        expect_window("restart_from_done", 0, 0);
    endtask

    task automatic test_slide_in_fetch();
        int lat;
        pulse(1'b1, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            slide = (lat == 5);
        end while (!valid && lat < LAT + 20);
        slide = 1'b0;
        n_checks++;
        if (lat !== LAT || packed_y() !== expected_window(0, 0)) begin
            n_fail++;
            $display("FAIL slide_in_fetch: got lat=%0d y=%h expected lat=%0d y=%h", lat, packed_y(), LAT, expected_window(0, 0));
        end
        check_quiet("slide_in_fetch_extra", 40);
        pulse(1'b0, 1'b1);
        expect_window("after_ignored_slide", 0, S);
        pulse(1'b1, 1'b1);
        expect_window("start_beats_slide", 0, 0);
    endtask

    task automatic test_reset_mid_fetch();
        pulse(1'b1, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0 || packed_y() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: got valid=%b y=%h expected valid=0 y=0", valid, packed_y());
        end
        @(negedge clk);
        rst = 1'b0;
        check_quiet("after_reset_no_valid", 40);
        pulse(1'b1, 1'b0);
        expect_window("after_reset_restart", 0, 0);
    endtask

    task automatic test_writes();
        write_word(SIZE, 8'hFF);
        write_word(127, 8'hFF);
        pulse(1'b1, 1'b0);
        expect_window("oob_write_ignored", 0, 0);
        write_word(COLS + 1, (model[COLS + 1] == 8'd0) ? 8'h5A : 8'h00);
        write_word(2, (model[2] == 8'd0) ? 8'h01 : 8'h00);
        pulse(1'b1, 1'b0);
        expect_window("write_in_ready", 0, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        slide       = 1'b0;
        ram_in_wen  = 1'b0;
        ram_in_addr = '0;
        ram_in_data = '0;
        for (int a = 0; a < SIZE; a++) model[a] = 8'd0;
        test_reset();
        test_load_and_first_window();
        test_full_scan();
        test_slide_in_fetch();
        test_reset_mid_fetch();
        test_writes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
